// File: rtl/rv32i_pkg.sv
// Shared RV32I constants and the ID/EX payload type used by the execute front end.
package rv32i_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    // funct3 encodings seen by the ALU and shifter
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SL      = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SR      = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    // funct7 bit that selects SUB / arithmetic right shift
    localparam int FUNCT7_ALT_BIT = 5;

    localparam logic [REG_AW-1:0] REG_X0 = '0;

    // Everything the stage latches from decode; forwarding is applied after the register
    typedef struct packed {
        logic [REG_AW-1:0] rs1_addr;
        logic [REG_AW-1:0] rs2_addr;
        logic [XLEN-1:0]   rs1_data;
        logic [XLEN-1:0]   rs2_data;
        logic [XLEN-1:0]   imm;
        logic              use_imm;
        logic [2:0]        funct3;
        logic [6:0]        funct7;
        logic [REG_AW-1:0] rd_addr;
    } id_ex_t;

endpackage

// File: rtl/fwd_mux.sv
// Operand bypass selector: x0, then EX/MEM, then MEM/WB, then register-file data.
module fwd_mux #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] addr,
    input  logic [XLEN-1:0]   raw_data,
    input  logic              mem_we,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [XLEN-1:0]   mem_data,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    output logic [XLEN-1:0]   operand
);
    import rv32i_pkg::*;

    // Priority select; the younger EX/MEM result wins over MEM/WB
    always_comb begin
        operand = raw_data;
        if (addr == REG_X0) begin
            operand = '0;
        end else if (mem_we && (mem_rd == addr)) begin
            operand = mem_data;
        end else if (wb_we && (wb_rd == addr)) begin
            operand = wb_data;
        end
    end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with valid/ready handshake, flush, and operand forwarding.
// Forwarding is resolved from the stored raw data every cycle, so a held
// instruction picks up results that retire while it is stalled.
module ex_operand_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_AW-1:0] in_rs1_addr,
    input  logic [REG_AW-1:0] in_rs2_addr,
    input  logic [XLEN-1:0]   in_rs1_data,
    input  logic [XLEN-1:0]   in_rs2_data,
    input  logic [XLEN-1:0]   in_imm,
    input  logic              in_use_imm,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [REG_AW-1:0] in_rd_addr,
    input  logic              mem_fwd_we,
    input  logic [REG_AW-1:0] mem_fwd_rd,
    input  logic [XLEN-1:0]   mem_fwd_data,
    input  logic              wb_fwd_we,
    input  logic [REG_AW-1:0] wb_fwd_rd,
    input  logic [XLEN-1:0]   wb_fwd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_x,
    output logic [XLEN-1:0]   out_y,
    output logic [2:0]        out_funct3,
    output logic [6:0]        out_funct7,
    output logic [REG_AW-1:0] out_rd_addr
);
    import rv32i_pkg::*;

    id_ex_t stage_reg;
    id_ex_t stage_next;
    id_ex_t in_fields;
    logic   valid_reg;
    logic   valid_next;
    logic   capture;

    logic [REG_AW-1:0] src_addr [2];
    logic [XLEN-1:0]   src_raw  [2];
    logic [XLEN-1:0]   src_fwd  [2];

    // The slot frees up whenever it is empty or being consumed this cycle
    assign in_ready = !valid_reg || out_ready;
    assign capture  = in_valid && in_ready && !flush;

    // Pack the decode fields into the stored payload layout
    always_comb begin
        in_fields          = '0;
        in_fields.rs1_addr = in_rs1_addr;
        in_fields.rs2_addr = in_rs2_addr;
        in_fields.rs1_data = in_rs1_data;
        in_fields.rs2_data = in_rs2_data;
        in_fields.imm      = in_imm;
        in_fields.use_imm  = in_use_imm;
        in_fields.funct3   = in_funct3;
        in_fields.funct7   = in_funct7;
        in_fields.rd_addr  = in_rd_addr;
    end

    // Next-state: flush kills the slot but leaves the payload untouched
    always_comb begin
        stage_next = capture ? in_fields : stage_reg;
        valid_next = valid_reg;
        if (flush) begin
            valid_next = 1'b0;
        end else if (capture) begin
            valid_next = 1'b1;
        end else if (valid_reg && out_ready) begin
            valid_next = 1'b0;
        end
    end

    // Pipeline register; reset clears both the valid bit and the payload
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_reg <= 1'b0;
            stage_reg <= '0;
        end else begin
            valid_reg <= valid_next;
            stage_reg <= stage_next;
        end
    end

    assign src_addr[0] = stage_reg.rs1_addr;
    assign src_addr[1] = stage_reg.rs2_addr;
    assign src_raw[0]  = stage_reg.rs1_data;
    assign src_raw[1]  = stage_reg.rs2_data;

    // One bypass selector per source register
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            fwd_mux #(
                .XLEN   (XLEN),
                .REG_AW (REG_AW)
            ) u_fwd (
                .addr     (src_addr[gi]),
                .raw_data (src_raw[gi]),
                .mem_we   (mem_fwd_we),
                .mem_rd   (mem_fwd_rd),
                .mem_data (mem_fwd_data),
                .wb_we    (wb_fwd_we),
                .wb_rd    (wb_fwd_rd),
                .wb_data  (wb_fwd_data),
                .operand  (src_fwd[gi])
            );
        end
    endgenerate

    assign out_valid   = valid_reg;
    assign out_x       = src_fwd[0];
    assign out_y       = stage_reg.use_imm ? stage_reg.imm : src_fwd[1];
    assign out_funct3  = stage_reg.funct3;
    assign out_funct7  = stage_reg.funct7;
    assign out_rd_addr = stage_reg.rd_addr;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: a transaction-level model plus literal spot checks.
module tb_ex_operand_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_rs1_addr = '0;
    logic [4:0]  in_rs2_addr = '0;
    logic [31:0] in_rs1_data = '0;
    logic [31:0] in_rs2_data = '0;
    logic [31:0] in_imm = '0;
    logic        in_use_imm = 1'b0;
    logic [2:0]  in_funct3 = '0;
    logic [6:0]  in_funct7 = '0;
    logic [4:0]  in_rd_addr = '0;
    logic        mem_fwd_we = 1'b0;
    logic [4:0]  mem_fwd_rd = '0;
    logic [31:0] mem_fwd_data = '0;
    logic        wb_fwd_we = 1'b0;
    logic [4:0]  wb_fwd_rd = '0;
    logic [31:0] wb_fwd_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_x;
    logic [31:0] out_y;
    logic [2:0]  out_funct3;
    logic [6:0]  out_funct7;
    logic [4:0]  out_rd_addr;

    int checks = 0;
    int failures = 0;
    logic cmp_en = 1'b0;

    ex_operand_stage #(.XLEN(32), .REG_AW(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_rs1_addr  (in_rs1_addr),
        .in_rs2_addr  (in_rs2_addr),
        .in_rs1_data  (in_rs1_data),
        .in_rs2_data  (in_rs2_data),
        .in_imm       (in_imm),
        .in_use_imm   (in_use_imm),
        .in_funct3    (in_funct3),
        .in_funct7    (in_funct7),
        .in_rd_addr   (in_rd_addr),
        .mem_fwd_we   (mem_fwd_we),
        .mem_fwd_rd   (mem_fwd_rd),
        .mem_fwd_data (mem_fwd_data),
        .wb_fwd_we    (wb_fwd_we),
        .wb_fwd_rd    (wb_fwd_rd),
        .wb_fwd_data  (wb_fwd_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_x        (out_x),
        .out_y        (out_y),
        .out_funct3   (out_funct3),
        .out_funct7   (out_funct7),
        .out_rd_addr  (out_rd_addr)
    );

    always #5 clk = ~clk;

    // Model: the instruction currently held by the stage, if any
    typedef struct {
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] imm;
        logic        ui;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
    } instr_t;

    instr_t m_ins = '{5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 3'd0, 7'd0, 5'd0};
    logic   m_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
        end
    endtask

    // Value a source must read as, given the results currently in flight
    function automatic logic [31:0] exp_src(input logic [4:0] a, input logic [31:0] raw);
        if (a == 5'd0) return 32'd0;
        if (mem_fwd_we && mem_fwd_rd == a) return mem_fwd_data;
        if (wb_fwd_we && wb_fwd_rd == a) return wb_fwd_data;
        return raw;
    endfunction

    // Transaction model of the slot: accept, consume, kill, reset
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_ins   <= '{5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 3'd0, 7'd0, 5'd0};
        end else if (flush) begin
            m_valid <= 1'b0;
        end else if (in_valid && (!m_valid || out_ready)) begin
            m_valid <= 1'b1;
            m_ins   <= '{in_rs1_addr, in_rs2_addr, in_rs1_data, in_rs2_data, in_imm,
                         in_use_imm, in_funct3, in_funct7, in_rd_addr};
        end else if (out_ready) begin
            m_valid <= 1'b0;
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc_valid", {31'd0, out_valid}, {31'd0, m_valid});
            check("cyc_in_ready", {31'd0, in_ready}, {31'd0, (!m_valid || out_ready)});
            check("cyc_x", out_x, exp_src(m_ins.a1, m_ins.d1));
            check("cyc_y", out_y, m_ins.ui ? m_ins.imm : exp_src(m_ins.a2, m_ins.d2));
            check("cyc_funct3", {29'd0, out_funct3}, {29'd0, m_ins.f3});
            check("cyc_funct7", {25'd0, out_funct7}, {25'd0, m_ins.f7});
            check("cyc_rd", {27'd0, out_rd_addr}, {27'd0, m_ins.rd});
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic present(input logic v, input logic [4:0] a1, input logic [4:0] a2,
                           input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                           input logic ui, input logic [2:0] f3, input logic [6:0] f7,
                           input logic [4:0] rd);
        in_valid    = v;
        in_rs1_addr = a1;
        in_rs2_addr = a2;
        in_rs1_data = d1;
        in_rs2_data = d2;
        in_imm      = imm;
        in_use_imm  = ui;
        in_funct3   = f3;
        in_funct7   = f7;
        in_rd_addr  = rd;
    endtask

    initial begin
        repeat (3) step();
        rst = 1'b0;
        cmp_en = 1'b1;
        #1;
        check("post_reset_valid", {31'd0, out_valid}, 32'd0);
        check("post_reset_ready", {31'd0, in_ready}, 32'd1);
        check("post_reset_x", out_x, 32'd0);
        check("post_reset_rd", {27'd0, out_rd_addr}, 32'd0);

        // Back-to-back stream with the consumer always ready
        out_ready = 1'b1;
        present(1'b1, 5'd1, 5'd2, 32'h100, 32'h200, 32'h0, 1'b0, 3'b000, 7'h00, 5'd3);
        step(); #1;
        $display("stream A: valid=%0d rd=%0d x=%h y=%h", out_valid, out_rd_addr, out_x, out_y);
        check("streamA_valid", {31'd0, out_valid}, 32'd1);
        check("streamA_x", out_x, 32'h100);
        check("streamA_y", out_y, 32'h200);
        present(1'b1, 5'd3, 5'd4, 32'h7, 32'h9, 32'hFFFF_FFF0, 1'b1, 3'b000, 7'h00, 5'd4);
        step(); #1;
        $display("stream B: valid=%0d rd=%0d x=%h y=%h", out_valid, out_rd_addr, out_x, out_y);
        check("streamB_valid", {31'd0, out_valid}, 32'd1);
        check("streamB_rd", {27'd0, out_rd_addr}, 32'd4);
        check("streamB_y", out_y, 32'hFFFF_FFF0);
        present(1'b1, 5'd6, 5'd0, 32'h8000_0000, 32'h0, 32'h405, 1'b1, 3'b101, 7'h20, 5'd7);
        step(); #1;
        $display("stream C (srai): valid=%0d rd=%0d x=%h y=%h", out_valid, out_rd_addr, out_x, out_y);
        check("srai_valid", {31'd0, out_valid}, 32'd1);
        check("srai_y", out_y, 32'h405);
        check("srai_funct3", {29'd0, out_funct3}, 32'd5);
        check("srai_funct7", {25'd0, out_funct7}, 32'h20);
        check("srai_x", out_x, 32'h8000_0000);
        in_valid = 1'b0;
        step(); #1;
        check("stream_drain", {31'd0, out_valid}, 32'd0);

        // Asynchronous reset while an instruction is held
        present(1'b1, 5'd8, 5'd9, 32'h88, 32'h99, 32'h0, 1'b0, 3'b000, 7'h00, 5'd10);
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        #1;
        check("prereset_valid", {31'd0, out_valid}, 32'd1);
        rst = 1'b1;
        #1;
        $display("mid-stream reset: valid=%0d x=%h in_ready=%0d", out_valid, out_x, in_ready);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_x", out_x, 32'd0);
        check("rst_ready", {31'd0, in_ready}, 32'd1);
        step();
        rst = 1'b0;

        // Forwarding priority on a held instruction
        present(1'b1, 5'd5, 5'd6, 32'h11, 32'h22, 32'h0, 1'b0, 3'b000, 7'h00, 5'd11);
        step();
        in_valid = 1'b0;
        mem_fwd_we = 1'b1; mem_fwd_rd = 5'd5; mem_fwd_data = 32'hAA;
        wb_fwd_we  = 1'b1; wb_fwd_rd  = 5'd5; wb_fwd_data  = 32'hBB;
        #1;
        $display("fwd both: x=%h y=%h", out_x, out_y);
        check("fwd_mem_wins", out_x, 32'hAA);
        check("fwd_y_raw", out_y, 32'h22);
        mem_fwd_we = 1'b0;
        #1;
        $display("fwd wb only: x=%h", out_x);
        check("fwd_wb", out_x, 32'hBB);
        wb_fwd_we = 1'b0;
        #1;
        check("fwd_none", out_x, 32'h11);
        step();

        // x0 source never forwards
        out_ready = 1'b1;
        present(1'b1, 5'd12, 5'd0, 32'h5, 32'hFFFF_FFFF, 32'h123, 1'b0, 3'b000, 7'h00, 5'd13);
        mem_fwd_we = 1'b1; mem_fwd_rd = 5'd0; mem_fwd_data = 32'hDEAD;
        step();
        in_valid = 1'b0;
        #1;
        $display("x0 source: x=%h y=%h", out_x, out_y);
        check("x0_y", out_y, 32'd0);
        check("x0_x", out_x, 32'h5);
        step();
        mem_fwd_we = 1'b0;
        #1;
        check("x0_drain", {31'd0, out_valid}, 32'd0);

        // Stall: consumer busy for 4 cycles while decode keeps presenting
        out_ready = 1'b0;
        present(1'b1, 5'd14, 5'd15, 32'h140, 32'h150, 32'h0, 1'b0, 3'b010, 7'h00, 5'd16);
        step();
        present(1'b1, 5'd17, 5'd18, 32'h170, 32'h180, 32'h9, 1'b1, 3'b100, 7'h00, 5'd19);
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                wb_fwd_we = 1'b1; wb_fwd_rd = 5'd14; wb_fwd_data = 32'hCAFE;
                #1;
                $display("stall wb forward: x=%h", out_x);
                check("stall_wb_fwd", out_x, 32'hCAFE);
            end
            step(); #1;
            $display("stall cycle %0d: in_ready=%0d rd=%0d", i, in_ready, out_rd_addr);
            check("stall_ready", {31'd0, in_ready}, 32'd0);
            check("stall_rd", {27'd0, out_rd_addr}, 32'd16);
            check("stall_valid", {31'd0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        #1;
        check("release_ready", {31'd0, in_ready}, 32'd1);
        step(); #1;
        wb_fwd_we = 1'b0;
        in_valid = 1'b0;
        $display("release capture: valid=%0d rd=%0d y=%h", out_valid, out_rd_addr, out_y);
        check("release_rd", {27'd0, out_rd_addr}, 32'd19);
        check("release_valid", {31'd0, out_valid}, 32'd1);
        check("release_y", out_y, 32'h9);

        // Flush with a held instruction and a new one offered
        present(1'b1, 5'd20, 5'd21, 32'h200, 32'h210, 32'h0, 1'b0, 3'b111, 7'h00, 5'd22);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        #1;
        $display("flush: valid=%0d rd=%0d", out_valid, out_rd_addr);
        check("flush_valid", {31'd0, out_valid}, 32'd0);
        check("flush_no_capture", {27'd0, out_rd_addr}, 32'd19);

        // Flush while stalled also clears
        present(1'b1, 5'd24, 5'd25, 32'h240, 32'h250, 32'h0, 1'b0, 3'b110, 7'h01, 5'd23);
        step();
        in_valid = 1'b0;
        out_ready = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        #1;
        $display("flush under stall: valid=%0d rd=%0d", out_valid, out_rd_addr);
        check("flush_stall_valid", {31'd0, out_valid}, 32'd0);
        check("flush_stall_rd", {27'd0, out_rd_addr}, 32'd23);
        out_ready = 1'b1;
        repeat (2) step();

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
